// File: rtl/code_conv_pkg.sv
// rtl/code_conv_pkg.sv - shared types and constants for the code-converter blocks
package code_conv_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bin2gray_core.sv
// rtl/bin2gray_core.sv - combinational binary-to-Gray converter
module bin2gray_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin arbiter sharing one bin2gray core among NREQ requesters
module gray_conv_arbiter
  import code_conv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_bin,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_gray,
  output logic [W-1:0]        out_bin,
  output logic [IDW-1:0]      out_id,
  output logic [CNT_W-1:0]    conv_cnt
);

  out_state_t     state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] win;
  logic           found;
  logic           slot_free;
  logic           accept;
  logic [W-1:0]   sel_bin;
  logic [W-1:0]   sel_gray;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
    return IDW'((int'(a) + b) % NREQ);
  endfunction

  assign slot_free = (state == EMPTY) || out_ready;
  assign accept    = slot_free && found;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot = '0;
    for (int j = 0; j < NREQ; j++) rot[j] = req_valid[wrap_add(rr_ptr, j)];
    pick  = '0;
    found = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pick  = IDW'(j);
        found = 1'b1;
      end
    end
    win       = wrap_add(rr_ptr, int'(pick));
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) sel_bin = req_bin[i*W +: W];
    end
  end

  bin2gray_core #(.W(W)) u_core (
    .b (sel_bin),
    .g (sel_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept)                            state_next = FULL;
    else if (state == FULL && out_ready)   state_next = EMPTY;
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_gray <= '0;
      out_bin  <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      out_gray <= sel_gray;
      out_bin  <= sel_bin;
      out_id   <= win;
      rr_ptr   <= wrap_add(win, 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          conv_cnt <= '0;
    else if (out_valid && out_ready && conv_cnt != '1)   conv_cnt <= conv_cnt + 1'b1;
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - scoreboard bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_gray;
  logic [W-1:0]      out_bin;
  logic [IDW-1:0]    out_id;
  logic [15:0]       conv_cnt;

  typedef struct {
    int         id;
    logic [3:0] bin;
    logic [3:0] gray;
  } exp_t;

  exp_t q[$];
  int   seen_id[$];
  int   seen_gray[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_rr = 0;
  bit   m_full = 0;
  int   m_cnt = 0;

  gray_conv_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .conv_cnt  (conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model, evaluated once per cycle between active edges.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_grant;
    bit              sfree;
    bit              fnd;
    int              gi;
    logic [3:0]      w;
    if (!rst_n) begin
      q.delete();
      m_full = 0;
      m_rr   = 0;
      m_cnt  = 0;
    end else begin
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
      if (m_full && q.size() > 0) begin
        check("out_id", 32'(out_id), 32'(q[0].id));
        check("out_bin", 32'(out_bin), 32'(q[0].bin));
        check("out_gray", 32'(out_gray), 32'(q[0].gray));
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          seen_id.push_back(q[0].id);
          seen_gray.push_back(int'(q[0].gray));
          void'(q.pop_front());
        end
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      sfree     = !m_full || out_ready;
      fnd       = 0;
      gi        = 0;
      exp_grant = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (!fnd && req_valid[(m_rr + k) % NREQ]) begin
          fnd = 1;
          gi  = (m_rr + k) % NREQ;
        end
      end
      if (sfree && fnd) exp_grant[gi] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_grant));
      if (sfree && fnd) begin
        w = req_bin[gi*W +: W];
        q.push_back('{id: gi, bin: w, gray: w ^ (w >> 1)});
        m_rr   = (gi + 1) % NREQ;
        m_full = 1;
      end else if (out_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_ids[8];
    int exp_gr[4];
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_gr  = '{0, 7, 15, 8};
    rst_n = 1'b0;
    req_valid = '0;
    req_bin = '0;
    out_ready = 1'b0;
    #1;
    apply_reset();

    repeat (5) step();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_req_ready", 32'(req_ready), 0);
    check("idle_conv_cnt", 32'(conv_cnt), 0);
    check("idle_out_gray", 32'(out_gray), 0);

    req_valid = 4'b0100;
    req_bin[2*W +: W] = 4'b1011;
    out_ready = 1'b1;
    #1;
    check("single_req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("single_gray", 32'(out_gray), 32'b1110);
    check("single_id", 32'(out_id), 2);
    check("single_bin", 32'(out_bin), 32'b1011);
    check("single_valid", 32'(out_valid), 1);
    step();
    check("single_cnt", 32'(conv_cnt), 1);
    step();

    apply_reset();
    seen_id.delete();
    seen_gray.delete();
    req_bin = {4'd15, 4'd10, 4'd5, 4'd0};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (8) step();
    req_valid = '0;
    repeat (2) step();
    check("fair_count", 32'(seen_id.size()), 8);
    for (int i = 0; i < 8 && i < seen_id.size(); i++) begin
      check($sformatf("fair_id%0d", i), 32'(seen_id[i]), 32'(exp_ids[i]));
      check($sformatf("fair_gray%0d", i), 32'(seen_gray[i]), 32'(exp_gr[i % 4]));
    end

    req_valid = 4'b1111;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_req_ready", 32'(req_ready), 0);
      check("hold_id", 32'(out_id), 0);
      check("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("release_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    repeat (2) step();

    req_valid = 4'b0001;
    for (int b = 0; b < 16; b++) begin
      req_bin[0 +: W] = 4'(b);
      step();
      check("sweep_gray", 32'(out_gray), 32'(b ^ (b >> 1)));
    end
    req_valid = '0;
    repeat (2) step();

    req_valid = 4'b1111;
    req_bin = {4'd3, 4'd9, 4'd6, 4'd12};
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_conv_cnt", 32'(conv_cnt), 0);
    check("arst_out_id", 32'(out_id), 0);
    check("arst_out_gray", 32'(out_gray), 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_first_grant", 32'(req_ready), 32'b0001);
    step();
    check("arst_first_id", 32'(out_id), 0);
    req_valid = '0;
    repeat (3) step();
    check("sb_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion datapath between `NREQ` requesters. Each requester presents a `W`-bit binary word on a valid/ready handshake. The block grants one requester per cycle, converts the word, and holds the Gray result in a one-entry output register with its own valid/ready handshake. It sits between the code-converter datapath and the blocks that need encoded position or pointer values.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 4: code width in bits, 2..16.
- `IDW`, 2: requester-ID width, equal to clog2(`NREQ`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i has a word.
- `req_bin`  in  NREQ*W  requester i word at bits [i*W +: W].
- `req_ready`  out  NREQ  one-hot or zero; bit i: word i is accepted this cycle.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_gray`  out  W  Gray code of the accepted word.
- `out_bin`  out  W  original binary word, for checking.
- `out_id`  out  IDW  index of the requester that was served.
- `conv_cnt`  out  16  total completed conversions; saturates at 16'hFFFF.

## Operation
- Two-state FSM on the output register:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `slot_free` = EMPTY or (FULL and `out_ready`).
- Arbitration is combinational and runs only when `slot_free`=1.
  - Search starts at `rr_ptr` and moves upward with modulo-`NREQ` wrap.
  - The first i with `req_valid[i]`=1 wins. `req_ready[i]` is set to 1 and every other bit is 0.
  - When `slot_free`=0, `req_ready` is all zeros.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On an accept (any `req_valid[i]` & `req_ready[i]`):
  - `out_bin` ← word i.
  - `out_gray` ← g[W-1] = b[W-1], and g[k] = b[k+1] ^ b[k] for every k < W-1.
  - `out_id` ← i, and the FSM goes to FULL.
  - `rr_ptr` ← (i+1) mod `NREQ`.
- When FULL, `out_ready`=1 and no request is pending, the FSM goes to EMPTY. `out_*` data holds its last value.
- When FULL and `out_ready`=0, all `out_*` signals stay stable and `rr_ptr` does not change.
- `conv_cnt` increments on each output handshake (`out_valid` & `out_ready`) and saturates at 16'hFFFF.
- If a requester drops `req_valid` before it is granted, its word is not captured and nothing is recorded.
- Reset asserted at any time, including mid-transfer, immediately clears:
  - FSM to EMPTY, `out_valid`=0.
  - `out_gray`=0, `out_bin`=0, `out_id`=0.
  - `rr_ptr`=0, `conv_cnt`=0.
  - Any pending result is dropped.

## Timing
- Latency: the accept in cycle N gives `out_valid`=1 with the data in cycle N+1.
- Throughput is one conversion per cycle while `out_ready`=1; this is the simultaneous drain-and-refill case.
- Fairness: with all requesters continuously valid and `out_ready`=1, grants go 0,1,…,NREQ-1,0,…
  - Any continuously-valid requester is served within `NREQ` accepts.
- All outputs are registered except `req_ready`.

## Structure
- Shared package `code_conv_pkg` holds:
  - FSM state encoding (EMPTY=1'b0, FULL=1'b1).
  - The `conv_cnt` width constant (16).
- Sub-module `bin2gray_core`: purely combinational, parameter `W`, ports `b` in and `g` out. One instance in this block.
- Round-robin search is a rotate, then fixed-priority pick, then un-rotate, implemented in this module.

## Test plan
- Reset, then idle for 5 cycles. Required: `out_valid`=0, `req_ready`=0, `conv_cnt`=0, `out_gray`=0.
- Requester 2 alone, `req_bin`=4'b1011, `out_ready`=1. Required:
  - `req_ready`=4'b0100 in that cycle.
  - Next cycle: `out_gray`=4'b1110, `out_id`=2, `out_bin`=4'b1011.
  - `conv_cnt`=1 after the output handshake.
- All 4 requesters valid for 8 cycles with words 0,5,10,15, `out_ready`=1. Required:
  - `out_id` sequence 0,1,2,3,0,1,2,3.
  - `out_gray` sequence 0000,0111,1111,1000, repeated.
- `out_ready`=0 for 3 cycles while FULL and all requesters valid. Required:
  - `req_ready`=0 throughout.
  - `out_*` stable, `rr_ptr` unchanged.
  - On release, the next grant is exactly `rr_ptr`.
- Exhaustive sweep of requester 0 with words 0..15. Every `out_gray` equals b ^ (b>>1).
- Assert `rst_n` low while FULL and requests pending. Required:
  - `out_valid`=0 asynchronously.
  - After release, the first grant goes to requester 0.
  - `conv_cnt`=0.
